// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial-side and parallel-side signals of the I2S receiver.
//   master modport : the receiver (drives clocks and the parallel word)
//   slave modport  : the ADC / downstream consumer side
interface i2s_rx_if;
    logic        sdin;
    logic        sclk;
    logic        lrclk;
    logic [23:0] data;
    logic        dvalid;
    logic        ch;

    modport master (
        input  sdin,
        output sclk,
        output lrclk,
        output data,
        output dvalid,
        output ch
    );

    modport slave (
        output sdin,
        input  sclk,
        input  lrclk,
        input  data,
        input  dvalid,
        input  ch
    );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: self-clocked I2S master receiver.
// Derives sclk = mclk/8 and lrclk = mclk/512 from a free-running 9-bit
// divider and deserialises 24-bit MSB-first words.
// The sample point is the sclk rising edge. The MSB is in slot 1 and the LSB is in slot 24.
// Optional build macro: I2S_RX_STEREO_EN
//   defined   -> both channels are captured; ch alternates 0/1.
//   undefined -> only left words are captured; ch is tied to 0.
module i2s_rx (
    input  logic         mclk,
    input  logic         rst,      // asynchronous, active-low
    i2s_rx_if.master     bus
);
    logic [8:0]  div_cnt_reg;
    logic [8:0]  div_cnt_next;
    logic        sclk_reg;
    logic        lrclk_reg;
    logic [23:0] shift_reg;
    logic [23:0] shift_next;
    logic [23:0] data_reg;
    logic        ch_reg;
    logic        ch_next;
    logic        dvalid_reg;

    logic [4:0]  slot;
    logic        sample_edge;
    logic        capture_en;
    logic        shift_en;
    logic        word_done;

    assign div_cnt_next = div_cnt_reg + 9'd1;
    assign slot         = div_cnt_reg[7:3];
    // The count moving from phase 3 to phase 4 is the sclk rising edge.
    assign sample_edge  = (div_cnt_reg[2:0] == 3'd3);

`ifdef I2S_RX_STEREO_EN
    assign capture_en = 1'b1;
    assign ch_next    = div_cnt_reg[8];
`else
    // Right half-frames are ignored entirely.
    assign capture_en = ~div_cnt_reg[8];
    assign ch_next    = 1'b0;
`endif

    assign shift_en  = sample_edge & capture_en & (slot >= 5'd1) & (slot <= 5'd23);
    assign word_done = sample_edge & capture_en & (slot == 5'd24);

    // shift_next is the register moved one place left with sdin entering at bit 0.
    // It also provides the completed word at the LSB edge.
    generate
        for (genvar gi = 0; gi < 24; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shift_next[gi] = bus.sdin;
            end else begin : g_upper
                assign shift_next[gi] = shift_reg[gi-1];
            end
        end
    endgenerate

    // Free-running divider. sclk and lrclk are registered copies of the next count,
    // so they always match div_cnt[2] and div_cnt[8].
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            div_cnt_reg <= 9'd0;
            sclk_reg    <= 1'b0;
            lrclk_reg   <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            sclk_reg    <= div_cnt_next[2];
            lrclk_reg   <= div_cnt_next[8];
        end
    end

    // Deserialiser. After 23 shifts, shift[22:0] holds only bits of the current word.
    // A new word therefore never needs an explicit clear.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            shift_reg <= 24'd0;
        end else if (shift_en) begin
            shift_reg <= shift_next;
        end
    end

    // Word completion: the LSB sample edge loads data and ch and pulses dvalid.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            data_reg   <= 24'd0;
            ch_reg     <= 1'b0;
            dvalid_reg <= 1'b0;
        end else begin
            dvalid_reg <= word_done;
            if (word_done) begin
                data_reg <= shift_next;
                ch_reg   <= ch_next;
            end
        end
    end

    assign bus.sclk   = sclk_reg;
    assign bus.lrclk  = lrclk_reg;
    assign bus.data   = data_reg;
    assign bus.dvalid = dvalid_reg;
    assign bus.ch     = ch_reg;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: table-driven bench for i2s_rx.
// Each table row is one 512-cycle frame (left word, right word, filler bit for unused slots).
// Expected strobes, positions and data are hand-written in the row.
// The bench follows I2S_RX_STEREO_EN in the same way as the design.
module tb_i2s_rx;
    logic mclk;
    logic rst;

    i2s_rx_if bus ();

    i2s_rx dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic        junk;
        logic [23:0] exp_left;
        logic [23:0] exp_right;
    } vec_t;

`ifdef I2S_RX_STEREO_EN
    localparam int EXP_STROBES = 2;
`else
    localparam int EXP_STROBES = 1;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;

    // Per-frame observations
    int          st_n;
    int          clk_err;
    logic [23:0] st_d   [2];
    logic        st_ch  [2];
    int          st_pos [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive ncyc cycles of a frame. The divider must be at 0 when this task is called.
    // Strobes are recorded after each edge, and the clock waveform is checked.
    task automatic run_frame(input logic [23:0] l, input logic [23:0] r,
                             input logic junk, input int ncyc);
        int          b;
        int          nc;
        logic [23:0] w;
        st_n    = 0;
        clk_err = 0;
        for (int k = 0; k < 2; k++) begin
            st_d[k]   = 24'd0;
            st_ch[k]  = 1'b0;
            st_pos[k] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            b = (c >> 3) & 31;
            w = (c >= 256) ? r : l;
            if (b >= 1 && b <= 24) bus.sdin = w[24-b];
            else                   bus.sdin = junk;
            @(posedge mclk);
            #1;
            nc = (c + 1) % 512;
            if (bus.sclk !== nc[2] || bus.lrclk !== nc[8]) clk_err++;
            if (bus.dvalid === 1'b1) begin
                if (st_n < 2) begin
                    st_d[st_n]   = bus.data;
                    st_ch[st_n]  = bus.ch;
                    st_pos[st_n] = nc;
                end
                st_n++;
            end else if (bus.dvalid !== 1'b0) begin
                clk_err++;
            end
        end
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        check({tag, "_clk_wave"}, clk_err, 0);
        check({tag, "_strobe_count"}, st_n, EXP_STROBES);
        check({tag, "_left_pos"}, st_pos[0], 196);
        check({tag, "_left_data"}, {8'd0, st_d[0]}, {8'd0, v.exp_left});
        check({tag, "_left_ch"}, {31'd0, st_ch[0]}, 32'd0);
`ifdef I2S_RX_STEREO_EN
        check({tag, "_right_pos"}, st_pos[1], 452);
        check({tag, "_right_data"}, {8'd0, st_d[1]}, {8'd0, v.exp_right});
        check({tag, "_right_ch"}, {31'd0, st_ch[1]}, 32'd1);
        check({tag, "_data_hold"}, {8'd0, bus.data}, {8'd0, v.exp_right});
`else
        check({tag, "_data_hold"}, {8'd0, bus.data}, {8'd0, v.exp_left});
`endif
        $display("%s: strobes=%0d L(pos=%0d ch=%0d data=%06h) R(pos=%0d ch=%0d data=%06h)",
                 tag, st_n, st_pos[0], st_ch[0], st_d[0], st_pos[1], st_ch[1], st_d[1]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sclk"},   {31'd0, bus.sclk},   32'd0);
        check({tag, "_lrclk"},  {31'd0, bus.lrclk},  32'd0);
        check({tag, "_data"},   {8'd0, bus.data},    32'd0);
        check({tag, "_dvalid"}, {31'd0, bus.dvalid}, 32'd0);
        check({tag, "_ch"},     {31'd0, bus.ch},     32'd0);
    endtask

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t rv;
        vecs[0] = '{left: 24'h00C491, right: 24'h000000, junk: 1'b0, exp_left: 24'h00C491, exp_right: 24'h000000};
        vecs[1] = '{left: 24'hFFFFFF, right: 24'h000000, junk: 1'b0, exp_left: 24'hFFFFFF, exp_right: 24'h000000};
        vecs[2] = '{left: 24'h000000, right: 24'hFFFFFF, junk: 1'b0, exp_left: 24'h000000, exp_right: 24'hFFFFFF};
        vecs[3] = '{left: 24'h0085C5, right: 24'h5A5A5A, junk: 1'b0, exp_left: 24'h0085C5, exp_right: 24'h5A5A5A};
        vecs[4] = '{left: 24'h123456, right: 24'hABCDEF, junk: 1'b0, exp_left: 24'h123456, exp_right: 24'hABCDEF};
        vecs[5] = '{left: 24'h000000, right: 24'h000000, junk: 1'b1, exp_left: 24'h000000, exp_right: 24'h000000};
        vecs[6] = '{left: 24'h800001, right: 24'h7FFFFE, junk: 1'b1, exp_left: 24'h800001, exp_right: 24'h7FFFFE};

        rst      = 1'b0;
        bus.sdin = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        check_reset_outputs("reset");
        @(negedge mclk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].left, vecs[i].right, vecs[i].junk, 512);
            check_frame($sformatf("vec%0d", i), vecs[i]);
        end

        // Mid-word reset: ones are partially shifted in, then reset is applied at div_cnt = 100.
        run_frame(24'hFFFFFF, 24'hFFFFFF, 1'b1, 100);
        check("midrst_no_early_strobe", st_n, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        rst = 1'b1;
        rv = '{left: 24'h000001, right: 24'h000002, junk: 1'b1, exp_left: 24'h000001, exp_right: 24'h000002};
        run_frame(rv.left, rv.right, rv.junk, 512);
        check_frame("post_reset", rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
